// File: rtl/running_high_pipelined.sv
// ----------------------------------------------------------------------------
// running_high_pipelined
//
// Sliding-window running maximum over the last DEPTH accepted samples.
// The window is a valid-gated shift register with a per-slot occupancy mask.
// The maximum is found by a comparator tree that has one register per level.
// Each accepted sample produces exactly one output beat, L+1 cycles later,
// where L = clog2(DEPTH).
//
// Parameters:
//   WIDTH  - sample width in bits (>= 1)
//   DEPTH  - window length; power of two, >= 2
//   SIGNED - 0: unsigned compare, 1: two's-complement compare
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   reset_n    - asynchronous active-low reset
//   in_valid   - accept in_data this cycle (no backpressure)
//   in_data    - sample
//   flush      - synchronous window clear; also kills beats in flight
//   out_valid  - one-cycle pulse per accepted sample
//   out_high   - max over the occupied slots for that sample (held between beats)
//   out_count  - occupied slots at that sample, 1..DEPTH (held between beats)
//   out_idx    - age of the max, 0 = newest (held between beats)
//
// Build option:
//   HIGH_INDEX_EN - when defined, the age of each candidate is carried through
//                   the tree and drives out_idx; otherwise out_idx is tied to 0.
// ----------------------------------------------------------------------------
module running_high_pipelined #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SIGNED = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_high,
    output logic [$clog2(DEPTH):0]     out_count,
    output logic [$clog2(DEPTH)-1:0]   out_idx
);

    localparam int unsigned L  = $clog2(DEPTH);
    localparam int unsigned AW = L;
    localparam int unsigned CW = L + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    // ------------------------------------------------------------------------
    // Window: slot 0 is the newest sample
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] occ_q, occ_d, occ_base;
    logic [CW-1:0]    fill_q, fill_d, fill_base;

    // Beat pipe: index 0 is the window stage, index k is tree level k.
    logic [L:0]       vld_q, vld_d;
    logic [CW-1:0]    cnt_q [L+1];
    logic [CW-1:0]    cnt_d [L+1];

    // Tree stored heap-style: node i has children 2i and 2i+1, node 1 is the
    // root, and heap positions DEPTH..2*DEPTH-1 are the window slots. Because
    // every node is registered, level k always sees level k-1 of the previous
    // cycle, so each window snapshot moves up the tree coherently.
    logic [WIDTH-1:0] node_val_q [1:DEPTH-1];
    logic [WIDTH-1:0] node_val_d [1:DEPTH-1];
    logic [DEPTH-1:1] node_vld_q, node_vld_d;

    logic [WIDTH-1:0]   all_val [1:2*DEPTH-1];
    logic [2*DEPTH-1:1] all_vld;

`ifdef HIGH_INDEX_EN
    logic [AW-1:0] node_age_q [1:DEPTH-1];
    logic [AW-1:0] node_age_d [1:DEPTH-1];
    logic [AW-1:0] all_age    [1:2*DEPTH-1];
    logic [AW-1:0] out_idx_q, out_idx_d;
`endif

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_high_q, out_high_d;
    logic [CW-1:0]    out_count_q, out_count_d;

    function automatic logic gt(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        if (SIGNED != 0) begin
            return $signed(x) > $signed(y);
        end
        return x > y;
    endfunction

    // ------------------------------------------------------------------------
    // Window and fill counter. Flush is applied before a same-cycle load.
    // ------------------------------------------------------------------------
    always_comb begin
        occ_base  = flush ? '0 : occ_q;
        fill_base = flush ? '0 : fill_q;
        data_d    = data_q;
        occ_d     = occ_base;
        fill_d    = fill_base;
        if (in_valid) begin
            data_d[0] = in_data;
            for (int s = 1; s < DEPTH; s++) begin
                data_d[s] = data_q[s-1];
            end
            occ_d  = {occ_base[DEPTH-2:0], 1'b1};
            fill_d = (fill_base == FullCount) ? fill_base : fill_base + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Beat pipe: valid and count travel alongside the tree levels
    // ------------------------------------------------------------------------
    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_valid;
        cnt_d[0] = fill_d;
        for (int k = 1; k <= L; k++) begin
            vld_d[k] = vld_q[k-1] & ~flush;
            cnt_d[k] = cnt_q[k-1];
        end
    end

    // ------------------------------------------------------------------------
    // Comparator tree
    // ------------------------------------------------------------------------
    always_comb begin
        for (int i = 1; i < DEPTH; i++) begin
            all_val[i] = node_val_q[i];
            all_vld[i] = node_vld_q[i];
`ifdef HIGH_INDEX_EN
            all_age[i] = node_age_q[i];
`endif
        end
        for (int s = 0; s < DEPTH; s++) begin
            all_val[DEPTH+s] = data_q[s];
            all_vld[DEPTH+s] = occ_q[s];
`ifdef HIGH_INDEX_EN
            all_age[DEPTH+s] = AW'(s);
`endif
        end
    end

    always_comb begin
        for (int i = 1; i < DEPTH; i++) begin
            logic take_b;
            // Left subtree always holds the younger slots, so on a tie the
            // left child is kept. An unoccupied left child never wins.
            take_b = ~all_vld[2*i] |
                     (all_vld[2*i+1] & gt(all_val[2*i+1], all_val[2*i]));
            node_vld_d[i] = all_vld[2*i] | all_vld[2*i+1];
            node_val_d[i] = take_b ? all_val[2*i+1] : all_val[2*i];
`ifdef HIGH_INDEX_EN
            node_age_d[i] = take_b ? all_age[2*i+1] : all_age[2*i];
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Output stage: outputs hold between beats
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid_d = vld_q[L] & ~flush;
        out_high_d  = out_high_q;
        out_count_d = out_count_q;
`ifdef HIGH_INDEX_EN
        out_idx_d   = out_idx_q;
`endif
        if (out_valid_d) begin
            out_high_d  = node_val_q[1];
            out_count_d = cnt_q[L];
`ifdef HIGH_INDEX_EN
            out_idx_d   = node_age_q[1];
`endif
        end
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
            end
            occ_q  <= '0;
            fill_q <= '0;
            vld_q  <= '0;
            for (int k = 0; k <= L; k++) begin
                cnt_q[k] <= '0;
            end
            for (int i = 1; i < DEPTH; i++) begin
                node_val_q[i] <= '0;
`ifdef HIGH_INDEX_EN
                node_age_q[i] <= '0;
`endif
            end
            node_vld_q  <= '0;
            out_valid_q <= 1'b0;
            out_high_q  <= '0;
            out_count_q <= '0;
`ifdef HIGH_INDEX_EN
            out_idx_q   <= '0;
`endif
        end else begin
            data_q <= data_d;
            occ_q  <= occ_d;
            fill_q <= fill_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            node_val_q <= node_val_d;
            node_vld_q <= node_vld_d;
`ifdef HIGH_INDEX_EN
            node_age_q <= node_age_d;
            out_idx_q  <= out_idx_d;
`endif
            out_valid_q <= out_valid_d;
            out_high_q  <= out_high_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_high  = out_high_q;
    assign out_count = out_count_q;
`ifdef HIGH_INDEX_EN
    assign out_idx   = out_idx_q;
`else
    assign out_idx   = '0;
`endif

endmodule
